alu_cmd_master: RTL

ALU_CMD_MASTER -- requirements
Module: alu_cmd_master

---
 rtl/alu_cmd_master.sv | 132 +++++++++++++
 1 files changed

// File: rtl/alu_cmd_master.sv
// Command master for an external combinational ALU: IDLE -> SETUP -> ENABLE -> RESP.
// Define ALU_CMD_FIFO_EN to place a 4-entry command FIFO in front of the FSM.
module alu_cmd_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        alu_en,
    output logic [2:0]  alu_sel,
    output logic [7:0]  alu_in0,
    output logic [7:0]  alu_in1,
    input  logic [15:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [2:0]  rsp_op,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SETUP, ENABLE, RESP} state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    state_t state;
    logic   live;
    logic   load;
    cmd_t   load_cmd;

    // Holds cmd_ready low through reset and releases it on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else        live <= 1'b1;
    end

`ifdef ALU_CMD_FIFO_EN
    cmd_t       fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;

    // Ready comes from the registered count, so a full FIFO refuses a push even while popping.
    assign full      = (count == 3'd4);
    assign empty     = (count == 3'd0);
    assign cmd_ready = live && !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = live && (state == IDLE) && !empty;
    assign load      = pop;
    assign load_cmd  = fifo_mem[rd_ptr];

    // NOTE: payload storage has no reset; only pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end
`else
    assign cmd_ready = live && (state == IDLE);
    assign load      = cmd_valid && cmd_ready;
    assign load_cmd  = {cmd_op, cmd_a, cmd_b};
`endif

    assign busy = (state != IDLE);

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch sees the pre-edge values, e.g. ENABLE captures rsp_op from the current alu_sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            alu_en    <= 1'b0;
            alu_sel   <= '0;
            alu_in0   <= '0;
            alu_in1   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_op    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        alu_sel <= load_cmd.op;
                        alu_in0 <= load_cmd.a;
                        alu_in1 <= load_cmd.b;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    alu_en <= 1'b1;
                    state  <= ENABLE;
                end
                ENABLE: begin
                    alu_en    <= 1'b0;
                    rsp_data  <= alu_out;
                    rsp_op    <= alu_sel;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        alu_sel   <= '0;
                        alu_in0   <= '0;
                        alu_in1   <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
